// File: rtl/io_host_seq.sv
// io_host_seq: sequences a single I/O-chip transaction. It writes a command
// nibble, pulses UPDATE high then low, and reads back 1..8 nibbles from
// consecutive addresses, which wrap modulo 64.
// Optional build macro IOHOST_CHECK_EN: when it is defined, ERR becomes sticky
// and is set whenever a captured byte's upper nibble is not 4'hF.
module io_host_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [3:0]  CMD,
  input  logic [5:0]  CMDADR,
  input  logic [5:0]  RDADR,
  input  logic [2:0]  RDLEN,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic        ERR,
  output logic        IO_EN,
  output logic        IO_WR,
  output logic [5:0]  IO_ADRS,
  output logic [7:0]  IO_DOUT,
  output logic        IO_UPDATE,
  input  logic [7:0]  IO_DIN
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRCMD, S_UPDH, S_UPDL, S_RDA, S_RDC, S_FIN
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_rdadr;
  logic [3:0]  r_len;     // 1..8
  logic [2:0]  r_idx;
  logic [31:0] r_result;
  logic        r_busy, r_done, r_io_en, r_io_wr, r_io_upd;
  logic [5:0]  r_io_adrs;
  logic [7:0]  r_io_dout;

  logic        w_io_en, w_io_wr, w_io_upd, w_last, w_accept;
  logic [5:0]  w_io_adrs, w_rd_adrs;
  logic [7:0]  w_io_dout;

  assign w_accept  = (r_state == S_IDLE) && START;
  assign w_last    = ({1'b0, r_idx} == (r_len - 4'd1));
  assign w_rd_adrs = r_rdadr + {3'b000, r_idx};

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus the pin values for that state, so every output is a flop
  always_comb begin
    w_next    = r_state;
    w_io_en   = 1'b0;
    w_io_wr   = 1'b0;
    w_io_upd  = 1'b0;
    w_io_adrs = r_io_adrs;
    w_io_dout = r_io_dout;
    case (r_state)
      S_IDLE: if (START) begin
        w_next    = S_WRCMD;
        w_io_en   = 1'b1;
        w_io_wr   = 1'b1;
        w_io_adrs = CMDADR;
        w_io_dout = {4'h0, CMD};
      end
      S_WRCMD: begin
        w_next   = S_UPDH;
        w_io_upd = 1'b1;
      end
      S_UPDH: w_next = S_UPDL;
      S_UPDL: begin
        w_next    = S_RDA;
        w_io_en   = 1'b1;
        w_io_adrs = w_rd_adrs;
      end
      S_RDA: w_next = S_RDC;
      S_RDC: begin
        if (w_last) begin
          w_next = S_FIN;
        end else begin
          w_next    = S_RDA;
          w_io_en   = 1'b1;
          w_io_adrs = w_rd_adrs + 6'd1;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_io_en   <= 1'b0;
      r_io_wr   <= 1'b0;
      r_io_upd  <= 1'b0;
      r_io_adrs <= 6'h00;
      r_io_dout <= 8'h00;
    end else begin
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_FIN);
      r_io_en   <= w_io_en;
      r_io_wr   <= w_io_wr;
      r_io_upd  <= w_io_upd;
      r_io_adrs <= w_io_adrs;
      r_io_dout <= w_io_dout;
    end
  end

  // Transaction context: latched at accept, so later input changes are ignored
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdadr  <= 6'h00;
      r_len    <= 4'd8;
      r_idx    <= 3'd0;
      r_result <= 32'h0;
    end else if (w_accept) begin
      r_rdadr  <= RDADR;
      r_len    <= (RDLEN == 3'd0) ? 4'd8 : {1'b0, RDLEN};
      r_idx    <= 3'd0;
      r_result <= 32'h0;
    end else if (r_state == S_RDC) begin
      r_result[{r_idx, 2'b00} +: 4] <= IO_DIN[3:0];
      if (!w_last) r_idx <= r_idx + 3'd1;
    end
  end

`ifdef IOHOST_CHECK_EN
  logic r_err;
  // Sticky flag for a bad upper nibble; cleared by reset or the next accept
  always_ff @(posedge CLK) begin
    if (RESET)                                      r_err <= 1'b0;
    else if (w_accept)                              r_err <= 1'b0;
    else if (r_state == S_RDC && IO_DIN[7:4] != 4'hF) r_err <= 1'b1;
  end
  assign ERR = r_err;
`else
  logic w_unused_din;
  assign w_unused_din = ^IO_DIN[7:4];
  assign ERR = 1'b0;
`endif

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign RESULT    = r_result;
  assign IO_EN     = r_io_en;
  assign IO_WR     = r_io_wr;
  assign IO_ADRS   = r_io_adrs;
  assign IO_DOUT   = r_io_dout;
  assign IO_UPDATE = r_io_upd;

endmodule

// File: doc/io_host_seq.md
IO_HOST_SEQ -- requirements
Module: io_host_seq

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port RESET  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port START  in  1  transaction request; sampled only in IDLE.
REQ-004 SHALL have port CMD  in  4  mode/command nibble written to the I/O chip.
REQ-005 SHALL have port CMDADR  in  6  I/O RAM address receiving CMD.
REQ-006 SHALL have port RDADR  in  6  first I/O RAM address read back.
REQ-007 SHALL have port RDLEN  in  3  nibbles to read; 0 means 8.
REQ-008 SHALL have port BUSY  out  1  high from START acceptance until DONE cycle inclusive.
REQ-009 SHALL have port DONE  out  1  one-cycle completion pulse.
REQ-010 SHALL have port RESULT  out  32  packed read nibbles, nibble i at bits [4i+3:4i].
REQ-011 SHALL have port ERR  out  1  sticky upper-nibble error flag (see Configuration).
REQ-012 SHALL have ports IO_EN out 1, IO_WR out 1, IO_ADRS out 6, IO_DOUT out 8, IO_UPDATE out 1 driving the I/O chip's ENABLE/WR/ADRS/IN/UPDATE, and IO_DIN in 8 from its OUT.

Function
REQ-013 SHALL implement states IDLE, WRCMD, UPDH, UPDL, RDA, RDC, FIN; all outputs registered.
REQ-014 IDLE: START=1 -> latch CMD, CMDADR, RDADR, RDLEN (0->8), clear RESULT to 0, clear nibble index i, go WRCMD; BUSY=1 from next cycle.
REQ-015 WRCMD (1 cycle): IO_EN=1, IO_WR=1, IO_ADRS=CMDADR, IO_DOUT={4'h0,CMD}; -> UPDH.
REQ-016 UPDH (1 cycle): IO_UPDATE=1, IO_EN=0; -> UPDL.
REQ-017 UPDL (1 cycle): IO_UPDATE=0, guaranteeing a fresh rising edge for the next transaction; -> RDA.
REQ-018 RDA (1 cycle): IO_EN=1, IO_WR=0, IO_ADRS=(RDADR+i) mod 64; -> RDC.
REQ-019 RDC (1 cycle): IO_EN=0; capture IO_DIN[3:0] into RESULT nibble i (chip read latency is one registered cycle); if i==len-1 -> FIN else i<=i+1, -> RDA.
REQ-020 FIN (1 cycle): DONE=1, BUSY=1; -> IDLE, where BUSY=0, DONE=0.
REQ-021 Transaction length SHALL be exactly 4+2*len cycles from first BUSY cycle through DONE cycle.
REQ-022 Address increment SHALL wrap 6'h3F -> 6'h00.
REQ-023 START while not in IDLE SHALL be ignored (not queued); START in FIN cycle ignored.
REQ-024 RESULT nibbles at index >= len SHALL read 0; RESULT SHALL be stable outside RDC captures.
REQ-025 Inputs CMD/CMDADR/RDADR/RDLEN changing during BUSY SHALL not affect the running transaction.
REQ-026 IO_EN, IO_WR, IO_UPDATE SHALL be 0 in IDLE and FIN; IO_DOUT[7:4] always 0.

Reset
REQ-027 RESET SHALL force IDLE and zero BUSY, DONE, RESULT, ERR, IO_EN, IO_WR, IO_ADRS, IO_DOUT, IO_UPDATE, i on the next edge.
REQ-028 RESET mid-transaction SHALL abort without DONE; START in the reset cycle ignored.

Configuration
REQ-029 With IOHOST_CHECK_EN defined: in RDC, IO_DIN[7:4]!=4'hF SHALL set ERR; ERR stays set until RESET or next accepted START clears it.
REQ-030 Without IOHOST_CHECK_EN: ERR SHALL be constant 0 and IO_DIN[7:4] ignored.

Verification
REQ-031 CMD=8, CMDADR=08, RDADR=00, RDLEN=2, chip nibbles 3,5 -> one write of 8'h08 at 08, one UPDATE pulse, DONE at cycle 8, RESULT=32'h00000053.
REQ-032 RDLEN=0, RDADR=3C, mem[3C..03]=1..8 -> addresses 3C,3D,3E,3F,00,01,02,03, RESULT=32'h87654321, 20 cycles.
REQ-033 START asserted every cycle for 30 cycles with RDLEN=1 -> back-to-back transactions, DONE every 7 cycles (6 busy + 1 idle), no START captured while BUSY.
REQ-034 RESET asserted during 2nd RDA of RDLEN=4 -> next cycle all outputs 0, no DONE, RESULT=0.
REQ-035 IOHOST_CHECK_EN defined, IO_DIN=8'h75 on a capture -> ERR=1 after that RDC, cleared at next START; undefined -> ERR stays 0.
